stage_2: RTL

// - Second pipeline stage of the AV1 arithmetic encoder; consumes stage_1 outputs (UU, VV, LUT terms, mode flags).
// - Owns the range state register: each symbol's new range is computed and normalised in one cycle, so a symbol can issue every cycle.
// - Emits low increment, shift count and normalised range to stage_3, which handles low update, carry and bitstream.

---
 rtl/av1_ec_pkg.sv | 21 ++
 rtl/s2_normalizer.sv | 27 ++
 rtl/stage_2.sv | 118 +++++++++++
 3 files changed

// File: rtl/av1_ec_pkg.sv
// Shared constants and width types for the AV1 arithmetic encoder stages.
package av1_ec_pkg;

  localparam int unsigned RANGE_W = 16;
  localparam int unsigned D_W     = 5;

  typedef logic [RANGE_W-1:0] range_t;
  typedef logic [D_W-1:0]     d_t;

  localparam range_t RANGE_RESET = 16'h8000;
  localparam range_t EC_MIN_PROB = 16'd4;
  localparam int unsigned PROB_SHIFT = 6;

  // ((r >> 8) * x) >> 1 with a full-width product, truncated to range width.
  function automatic range_t mul_term(input range_t r, input range_t x);
    logic [2*RANGE_W-1:0] p;
    p = {{(RANGE_W+8){1'b0}}, r[RANGE_W-1:8]} * {{RANGE_W{1'b0}}, x};
    return range_t'(p >> 1);
  endfunction

endpackage

// File: rtl/s2_normalizer.sv
// Range normaliser: shift count d = leading zeros of r, and r << d.
// An all-zero input yields d = RANGE_WIDTH and a zero result.
module s2_normalizer #(
  parameter int unsigned RANGE_WIDTH = 16,
  parameter int unsigned D_SIZE      = 5
) (
  input  logic [RANGE_WIDTH-1:0] range_in,
  output logic [D_SIZE-1:0]      d,
  output logic [RANGE_WIDTH-1:0] range_norm
);

  logic found;

  // Priority search for the most significant set bit.
  always_comb begin
    d     = D_SIZE'(RANGE_WIDTH);
    found = 1'b0;
    for (int i = RANGE_WIDTH - 1; i >= 0; i--) begin
      if (!found && range_in[i]) begin
        d     = D_SIZE'(RANGE_WIDTH - 1 - i);
        found = 1'b1;
      end
    end
    range_norm = range_in << d;
  end

endmodule

// File: rtl/stage_2.sv
// Stage 2 of the AV1 arithmetic encoder: range update and normalisation.
// Optional macro S2_ERROR_FLAG_EN adds a sticky range_err output.
module stage_2
  import av1_ec_pkg::*;
#(
  parameter int unsigned RANGE_WIDTH    = 16,
  parameter int unsigned SYMBOL_WIDTH   = 4,
  parameter int unsigned LUT_DATA_WIDTH = 16,
  parameter int unsigned D_SIZE         = 5
) (
  input  logic                      clk_stage_2,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      restart,
  input  logic                      COMP_mux_1,
  input  logic                      bool_flag,
  input  logic [SYMBOL_WIDTH-1:0]   symbol_in,
  input  logic [RANGE_WIDTH-1:0]    UU,
  input  logic [RANGE_WIDTH-1:0]    VV,
  input  logic [LUT_DATA_WIDTH-1:0] lut_u_in,
  input  logic [LUT_DATA_WIDTH-1:0] lut_v_in,
  output logic                      out_valid,
  output logic [RANGE_WIDTH-1:0]    low_add,
  output logic [D_SIZE-1:0]         d_out,
  output logic [RANGE_WIDTH-1:0]    range_out
`ifdef S2_ERROR_FLAG_EN
  ,
  output logic                      range_err
`endif
);

  range_t range_q;
  range_t base, m_u, m_v, u, v, la, r_new, r_norm;
  d_t     d_new;
  logic   bad_sym;

  // Mode mux: select base range, compute low increment and unnormalised new range.
  always_comb begin
    base    = restart ? RANGE_RESET : range_q;
    m_u     = mul_term(base, UU);
    m_v     = mul_term(base, VV);
    u       = '0;
    v       = '0;
    la      = '0;
    r_new   = '0;
    bad_sym = 1'b0;
    if (bool_flag) begin
      v = m_v + EC_MIN_PROB;
      if (symbol_in[0]) begin
        la    = base - v;
        r_new = v;
      end else begin
        la    = '0;
        r_new = base - v;
      end
    end else if (COMP_mux_1) begin
      u       = m_u + range_t'(lut_u_in);
      v       = m_v + range_t'(lut_v_in);
      la      = base - u;
      r_new   = u - v;
      bad_sym = (u <= v);
    end else begin
      v     = m_v + range_t'(lut_v_in);
      la    = '0;
      r_new = base - v;
    end
    if (r_new == '0) bad_sym = 1'b1;
  end

  s2_normalizer #(
    .RANGE_WIDTH(RANGE_WIDTH),
    .D_SIZE     (D_SIZE)
  ) u_norm (
    .range_in  (r_new),
    .d         (d_new),
    .range_norm(r_norm)
  );

  // Range state and registered outputs; restart alone only reloads the range.
  always_ff @(posedge clk_stage_2 or posedge reset) begin
    if (reset) begin
      range_q   <= RANGE_RESET;
      out_valid <= 1'b0;
      low_add   <= '0;
      d_out     <= '0;
      range_out <= RANGE_RESET;
    end else if (in_valid) begin
      range_q   <= r_norm;
      out_valid <= 1'b1;
      low_add   <= la;
      d_out     <= d_new;
      range_out <= r_norm;
    end else begin
      out_valid <= 1'b0;
      if (restart) range_q <= RANGE_RESET;
    end
  end

`ifdef S2_ERROR_FLAG_EN
  logic err_d;

  // Sticky error: cleared by restart, set by an illegal valid symbol.
  always_comb begin
    err_d = restart ? 1'b0 : range_err;
    if (in_valid && bad_sym) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk_stage_2 or posedge reset) begin
    if (reset) range_err <= 1'b0;
    else       range_err <= err_d;
  end
`else
  logic unused_bad;
  assign unused_bad = bad_sym;
`endif

endmodule
